rom_arb: RTL and testbench
==========================

ROM_ARB -- requirements
Module: rom_arb

Interface
REQ-001 Parameter: ROM_WORDS, default 256, number of 32-bit words in the attached ROM.
REQ-002 CLK  input  1  clock, all state updates on posedge.
REQ-003 RST_N  input  1  reset, synchronous, active-low.
REQ-004 I_REQ  input  1  instruction-fetch read request.
REQ-005 I_ADDR  input  32  instruction-fetch byte address.
REQ-006 I_GNT  output  1  instruction request accepted this cycle (combinational).
REQ-007 I_RVALID  output  1  instruction read data valid.
REQ-008 I_RDATA  output  32  instruction read data.
REQ-009 I_RERR  output  1  instruction address out of range, qualified by I_RVALID.
REQ-010 I_READY  input  1  fetch side accepts response.
REQ-011 D_REQ, D_ADDR, D_GNT, D_RVALID, D_RDATA, D_RERR, D_READY  same directions, widths and meanings as the I_ ports, for the data-load requester.
REQ-012 ROM_A  output  32  byte address to ROM, sampled by ROM on posedge.
REQ-013 ROM_RD  input  32  ROM read data, valid the cycle after ROM_A is sampled.

Function
REQ-014 Single shared ROM port; at most one read outstanding.
REQ-015 States: IDLE (nothing outstanding), RESP (response driven straight from ROM_RD), HOLD (response driven from skid register).
REQ-016 Grant allowed in IDLE, or in RESP/HOLD in the cycle the current response handshakes (RVALID and READY both 1); otherwise both GNTs 0.
REQ-017 On grant, ROM_A = granted ADDR unchanged (low two bits passed through); with no grant ROM_A holds its last granted value.
REQ-018 Contention default: D wins over I; uncontended requester granted immediately.
REQ-019 At most one GNT high per cycle; GNT never high when its REQ is low.
REQ-020 Grant in cycle N -> RVALID of the granted port high in cycle N+1 with RDATA = ROM_RD; other port RVALID stays 0.
REQ-021 RVALID high with READY low at end of RESP -> capture ROM_RD into skid register, go to HOLD; RVALID and RDATA held stable until READY.
REQ-022 Handshake with no new grant -> IDLE; handshake with new grant -> RESP for the new port next cycle (throughput one word per cycle).
REQ-023 Range check: ADDR[31:2] >= ROM_WORDS -> response RDATA = 0, RERR = 1; in range -> RERR = 0.
REQ-024 REQ may drop without grant; no request is remembered across cycles.
REQ-025 RDATA is 0 whenever its RVALID is 0.

Reset
REQ-026 RST_N low at posedge -> IDLE, all GNT/RVALID/RERR/RDATA 0, ROM_A 0, skid register 0, round-robin pointer favours D.
REQ-027 Reset mid-operation drops any outstanding or held response; no RVALID in the cycle after reset deasserts unless a grant occurred in the first cycle after reset release.
REQ-028 GNT held 0 in any cycle RST_N is low.

Configuration
REQ-029 Macro ROM_ARB_RR_EN defined: contention resolved round-robin; the port not granted at the last contended grant wins next contention; pointer updates only on contended grants.
REQ-030 Macro ROM_ARB_RR_EN undefined: fixed D-over-I priority per REQ-018; no pointer register exists.

Verification
REQ-031 I_REQ=1 I_ADDR=0x8, D_REQ=0, ROM word2=0x20000083, I_READY=1 -> I_GNT cycle N, I_RVALID cycle N+1 with I_RDATA=0x20000083, I_RERR=0.
REQ-032 I_REQ and D_REQ both 1 every cycle, both READY=1, macro off -> D_GNT every cycle, I_GNT never; macro on -> grants alternate D,I,D,I.
REQ-033 D granted at addr 0x4, D_READY=0 for 3 cycles then 1, ROM_A changed meanwhile -> D_RVALID high 4 cycles, D_RDATA constant = word1, no grants until handshake cycle.
REQ-034 I_ADDR=0x400 with ROM_WORDS=256 -> I_RVALID with I_RDATA=0, I_RERR=1.
REQ-035 RST_N low in HOLD state -> next cycle all RVALID 0, state IDLE, held word never delivered.
REQ-036 Back-to-back I requests at 0x0,0x4,0x8 with I_READY=1 -> three RVALID cycles consecutive, data words 0,1,2 in order.

Source files
------------

// File: rtl/rom_arb.sv
// Two-requester (instruction fetch / data load) arbiter in front of a single-port ROM,
// one read outstanding, skid register for back-pressure. Macro ROM_ARB_RR_EN enables round-robin.
module rom_arb #(
   parameter int ROM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   output logic        i_rerr,
   input  logic        i_ready,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_rerr,
   input  logic        d_ready,
   output logic [31:0] rom_a,
   input  logic [31:0] rom_rd
);

   typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;

   state_t      state, state_nxt;
   logic        owner_d;
   logic        err;
   logic [31:0] skid;
   logic [31:0] rom_a_q;
   logic        busy, hs, gnt_ok, any_gnt, pick_d, oor;
   logic [31:0] gnt_addr, rsp_data;

`ifdef ROM_ARB_RR_EN
   logic ptr_d;
   assign pick_d = ptr_d;
`else
   assign pick_d = 1'b1;
`endif

   always_comb begin
      busy      = 1'b0;
      hs        = 1'b0;
      gnt_ok    = 1'b0;
      d_gnt     = 1'b0;
      i_gnt     = 1'b0;
      any_gnt   = 1'b0;
      gnt_addr  = i_addr;
      oor       = 1'b0;
      rom_a     = rom_a_q;
      rsp_data  = 32'h0;
      state_nxt = state;

      busy    = (state != IDLE);
      hs      = busy && (owner_d ? d_ready : i_ready);
      gnt_ok  = rst_n && (!busy || hs);
      d_gnt   = gnt_ok && d_req && (!i_req || pick_d);
      i_gnt   = gnt_ok && i_req && !d_gnt;
      any_gnt = d_gnt || i_gnt;
      if (d_gnt) gnt_addr = d_addr;
      oor = ({2'b00, gnt_addr[31:2]} >= 32'(ROM_WORDS));
      if (any_gnt) rom_a = gnt_addr;

      // Out-of-range responses are zeroed here so the skid only ever holds clean data.
      if (state == HOLD) rsp_data = skid;
      else if (!err)     rsp_data = rom_rd;

      case (state)
         IDLE:    if (any_gnt) state_nxt = RESP;
         RESP:    if (hs) state_nxt = any_gnt ? RESP : IDLE;
                  else    state_nxt = HOLD;
         HOLD:    if (hs) state_nxt = any_gnt ? RESP : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign i_rvalid = busy && !owner_d;
   assign d_rvalid = busy && owner_d;
   assign i_rdata  = i_rvalid ? rsp_data : 32'h0;
   assign d_rdata  = d_rvalid ? rsp_data : 32'h0;
   assign i_rerr   = i_rvalid && err;
   assign d_rerr   = d_rvalid && err;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         owner_d <= 1'b0;
         err     <= 1'b0;
         skid    <= 32'h0;
         rom_a_q <= 32'h0;
`ifdef ROM_ARB_RR_EN
         ptr_d   <= 1'b1;
`endif
      end else begin
         state <= state_nxt;
         if (any_gnt) begin
            owner_d <= d_gnt;
            err     <= oor;
            rom_a_q <= gnt_addr;
         end
         if (state == RESP && !hs) skid <= rsp_data;
`ifdef ROM_ARB_RR_EN
         // Loser of a contended grant is favoured next time.
         if (any_gnt && i_req && d_req) ptr_d <= !d_gnt;
`endif
      end
   end

endmodule

// File: tb/tb_rom_arb.sv
// Directed, table-driven bench for rom_arb with a behavioural ROM (1-cycle read latency).
// Expectations cover both builds (ROM_ARB_RR_EN on or off).
module tb_rom_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req, d_req, i_ready, d_ready;
   logic [31:0] i_addr, d_addr;
   logic        i_gnt, i_rvalid, i_rerr, d_gnt, d_rvalid, d_rerr;
   logic [31:0] i_rdata, d_rdata, rom_a;
   logic [31:0] rom_rd;
   logic [31:0] rom [0:255];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rom_arb #(.ROM_WORDS(256)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
      .i_rdata(i_rdata), .i_rerr(i_rerr), .i_ready(i_ready),
      .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
      .d_rdata(d_rdata), .d_rerr(d_rerr), .d_ready(d_ready),
      .rom_a(rom_a), .rom_rd(rom_rd)
   );

   // Out-of-range reads return junk so the DUT must zero them itself.
   always @(posedge clk)
      rom_rd <= (rom_a[31:10] == 22'h0) ? rom[rom_a[9:2]] : 32'hDEAD_BEEF;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        ireq;
      logic [31:0] iaddr;
      logic        dreq;
      logic [31:0] daddr;
      logic        irdy, drdy;
      logic        e_ignt, e_dgnt, e_irv, e_drv;
      logic [31:0] e_irdata, e_drdata;
      logic        e_irerr, e_drerr;
      logic [31:0] e_roma;
   } vec_t;

   function automatic logic [31:0] w(input int i);
      return (i == 2) ? 32'h2000_0083 : 32'h1000_0000 + 32'(i);
   endfunction

   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                        input logic [31:0] da, input logic iy, input logic dy);
      i_req = ir; i_addr = ia; d_req = dr; d_addr = da; i_ready = iy; d_ready = dy;
   endtask

   vec_t vt [19];

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = w(i);

      //          ireq iaddr      dreq daddr     irdy drdy ignt dgnt irv drv irdata      drdata      ierr derr roma
      vt[0]  = '{1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
      vt[1]  = '{1'b1, 32'h8,    1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8};
      vt[2]  = '{1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, w(2),  32'h0, 1'b0, 1'b0, 32'h8};
      vt[3]  = '{1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8};
      vt[4]  = '{1'b1, 32'h0,    1'b1, 32'h4,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h4};
      vt[5]  = '{1'b1, 32'h400,  1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, w(1),  1'b0, 1'b0, 32'h400};
      vt[6]  = '{1'b0, 32'h0,    1'b1, 32'hC,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hC};
      vt[7]  = '{1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, w(3),  1'b0, 1'b0, 32'hC};
      vt[8]  = '{1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hC};
      vt[9]  = '{1'b1, 32'h0,    1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
      vt[10] = '{1'b1, 32'h4,    1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, w(0),  32'h0, 1'b0, 1'b0, 32'h4};
      vt[11] = '{1'b1, 32'h8,    1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, w(1),  32'h0, 1'b0, 1'b0, 32'h8};
      vt[12] = '{1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, w(2),  32'h0, 1'b0, 1'b0, 32'h8};
      vt[13] = '{1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8};
      vt[14] = '{1'b0, 32'h0,    1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h10};
      vt[15] = '{1'b1, 32'h14,   1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, w(4),  1'b0, 1'b0, 32'h10};
      vt[16] = '{1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, w(4),  1'b0, 1'b0, 32'h10};
      vt[17] = '{1'b0, 32'h0,    1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, w(4),  1'b0, 1'b0, 32'h10};
      vt[18] = '{1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h10};

      rst_n = 1'b0;
      drive(1'b1, 32'h0, 1'b1, 32'h4, 1'b1, 1'b1);
      #1;
      chk("gnt_i_in_reset", {31'h0, i_gnt}, 32'h0);
      chk("gnt_d_in_reset", {31'h0, d_gnt}, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);

      for (int v = 0; v < 19; v++) begin
         @(negedge clk);
         drive(vt[v].ireq, vt[v].iaddr, vt[v].dreq, vt[v].daddr, vt[v].irdy, vt[v].drdy);
         #1;
         chk($sformatf("v%0d i_gnt", v),    {31'h0, i_gnt},    {31'h0, vt[v].e_ignt});
         chk($sformatf("v%0d d_gnt", v),    {31'h0, d_gnt},    {31'h0, vt[v].e_dgnt});
         chk($sformatf("v%0d i_rvalid", v), {31'h0, i_rvalid}, {31'h0, vt[v].e_irv});
         chk($sformatf("v%0d d_rvalid", v), {31'h0, d_rvalid}, {31'h0, vt[v].e_drv});
         chk($sformatf("v%0d i_rdata", v),  i_rdata,           vt[v].e_irdata);
         chk($sformatf("v%0d d_rdata", v),  d_rdata,           vt[v].e_drdata);
         chk($sformatf("v%0d i_rerr", v),   {31'h0, i_rerr},   {31'h0, vt[v].e_irerr});
         chk($sformatf("v%0d d_rerr", v),   {31'h0, d_rerr},   {31'h0, vt[v].e_drerr});
         chk($sformatf("v%0d rom_a", v),    rom_a,             vt[v].e_roma);
      end

      // Back-pressure: D held 4 cycles, ROM word changes underneath, skid must hold word1.
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b1, 32'h4, 1'b1, 1'b0);
      #1;
      chk("hold d_gnt", {31'h0, d_gnt}, 32'h1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         drive(1'b1, 32'h20, 1'b0, 32'h0, 1'b1, (k == 3));
         #1;
         chk($sformatf("hold%0d d_rvalid", k), {31'h0, d_rvalid}, 32'h1);
         chk($sformatf("hold%0d d_rdata", k),  d_rdata, w(1));
         chk($sformatf("hold%0d i_gnt", k),    {31'h0, i_gnt}, {31'h0, (k == 3)});
         chk($sformatf("hold%0d rom_a", k),    rom_a, (k == 3) ? 32'h20 : 32'h4);
         if (k == 0) rom[1] = 32'h0BAD_0BAD;
      end
      rom[1] = w(1);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
      #1;
      chk("after_hold i_rvalid", {31'h0, i_rvalid}, 32'h1);
      chk("after_hold i_rdata",  i_rdata, w(8));
      chk("after_hold d_rvalid", {31'h0, d_rvalid}, 32'h0);

      // Reset while in HOLD: the held word is dropped.
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b1, 32'h8, 1'b1, 1'b0);
      #1;
      chk("rsthold d_gnt", {31'h0, d_gnt}, 32'h1);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      chk("rsthold in_hold d_rvalid", {31'h0, d_rvalid}, 32'h1);
      chk("rsthold in_hold d_rdata",  d_rdata, w(2));
      rst_n = 1'b0;
      drive(1'b1, 32'h0, 1'b1, 32'h4, 1'b1, 1'b0);
      #1;
      chk("rsthold i_gnt_low", {31'h0, i_gnt}, 32'h0);
      chk("rsthold d_gnt_low", {31'h0, d_gnt}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
      #1;
      chk("postrst d_rvalid", {31'h0, d_rvalid}, 32'h0);
      chk("postrst i_rvalid", {31'h0, i_rvalid}, 32'h0);
      chk("postrst d_rdata",  d_rdata, 32'h0);
      chk("postrst rom_a",    rom_a, 32'h0);
      @(negedge clk);
      #1;
      chk("postrst2 d_rvalid", {31'h0, d_rvalid}, 32'h0);

      // Continuous contention: fixed priority vs round-robin alternation.
      for (int k = 0; k < 6; k++) begin
         logic exp_d;
`ifdef ROM_ARB_RR_EN
         exp_d = (k % 2 == 0);
`else
         exp_d = 1'b1;
`endif
         @(negedge clk);
         drive(1'b1, 32'h0, 1'b1, 32'h4, 1'b1, 1'b1);
         #1;
         chk($sformatf("cont%0d d_gnt", k), {31'h0, d_gnt}, {31'h0, exp_d});
         chk($sformatf("cont%0d i_gnt", k), {31'h0, i_gnt}, {31'h0, !exp_d});
      end
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      chk("drain idle d_rvalid", {31'h0, d_rvalid}, 32'h0);
      chk("drain idle i_rvalid", {31'h0, i_rvalid}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
